// File: rtl/heston_path_sequencer.sv
// heston_path_sequencer: start-up sequencing and terminal-price capture for N_CORES Heston cores.
// The FSM walks IDLE -> LOAD -> KICK -> WARM -> RUN -> FIN and drives the shared core reset and
// enable. At the last step of every path it pushes all core prices into a first-word
// fall-through output FIFO with a valid/ready handshake. Every output comes straight from a flop.
// Optional build macro HPC_PATH_TAG_EN: store a 16-bit path index with each FIFO entry and present
// it on out_tag; without it out_tag is tied to zero.
module heston_path_sequencer #(
  parameter int unsigned N_CORES    = 2,
  parameter int unsigned PW         = 32,
  parameter int unsigned STEPS      = 1464,
  parameter int unsigned WARMUP     = 6,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [15:0]           num_paths,
  input  logic [N_CORES*PW-1:0] price_in,
  output logic                  core_rst,
  output logic                  core_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_CORES*PW-1:0] out_price,
  output logic [15:0]           out_tag,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned DW  = N_CORES * PW;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned SW  = (STEPS > 1) ? $clog2(STEPS) : 1;
  // One counter serves both LOAD (2 cycles) and WARM (WARMUP cycles).
  localparam int unsigned PCW = $clog2(WARMUP + 2);

  localparam logic [SW-1:0]  LastStep  = SW'(STEPS - 1);
  localparam logic [PCW-1:0] LastLoad  = PCW'(1);
  localparam logic [PCW-1:0] LastWarm  = PCW'(WARMUP - 1);
  localparam logic [CW-1:0]  FullCount = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StKick,
    StWarm,
    StRun,
    StFin
  } state_e;

  // Sequencer state
  state_e          state_q, state_d;
  logic [PCW-1:0]  phase_q, phase_d;
  logic [SW-1:0]   step_q, step_d;
  logic [15:0]     path_q, path_d;
  logic [15:0]     npaths_q, npaths_d;
  logic [15:0]     path_inc;
  logic            capture;
  logic            start_acc;

  // Registered control outputs
  logic            core_rst_q, core_en_q, busy_q, done_q, ovf_q;

  // Output FIFO
  logic [DW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q;
  logic [DW-1:0]   price_q, price_d;
  logic            pop, full, wr_en, drop, bypass;

  assign path_inc = path_q + 16'd1;

  // FSM next state, step/path counting and capture strobe; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    step_d    = step_q;
    path_d    = path_q;
    npaths_d  = npaths_q;
    capture   = 1'b0;
    start_acc = 1'b0;
    if (abort) begin
      state_d = StIdle;
      phase_d = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            start_acc = 1'b1;
            npaths_d  = num_paths;
            path_d    = '0;
            phase_d   = '0;
            state_d   = (num_paths == 16'd0) ? StFin : StLoad;
          end
        end
        StLoad: begin
          if (phase_q == LastLoad) begin
            phase_d = '0;
            state_d = StKick;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        StKick: begin
          phase_d = '0;
          state_d = StWarm;
        end
        StWarm: begin
          if (phase_q == LastWarm) begin
            phase_d = '0;
            step_d  = '0;
            state_d = StRun;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        StRun: begin
          if (step_q == LastStep) begin
            // Paths run back-to-back: the step counter wraps without re-initialising the cores.
            capture = 1'b1;
            step_d  = '0;
            path_d  = path_inc;
            if (path_inc == npaths_q) begin
              state_d = StFin;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        StFin: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // FSM registers; core controls are decoded from the next state so they leave a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      step_q     <= '0;
      path_q     <= '0;
      npaths_q   <= '0;
      core_rst_q <= 1'b1;
      core_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      step_q     <= step_d;
      path_q     <= path_d;
      npaths_q   <= npaths_d;
      core_rst_q <= (state_d == StIdle) || (state_d == StLoad);
      core_en_q  <= (state_d == StLoad) || (state_d == StKick);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StFin);
      // A new run clears the sticky flag; abort leaves it untouched.
      if (start_acc) begin
        ovf_q <= 1'b0;
      end else if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // FIFO pointer/count update and next head word; a full FIFO still accepts a push when popped.
  always_comb begin
    pop     = valid_q & out_ready;
    full    = (count_q == FullCount);
    wr_en   = capture & (~full | pop);
    drop    = capture & full & ~pop;
    wptr_d  = wptr_q + AW'(wr_en);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(wr_en) - CW'(pop);
    if (abort) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
    // The word being written becomes the head when the FIFO is empty after any pop.
    bypass  = wr_en & (rptr_d == wptr_q);
    price_d = '0;
    if (count_d != '0) begin
      price_d = bypass ? price_in : mem_q[rptr_d];
    end
  end

  // FIFO control registers and registered head presentation.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      price_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= (count_d != '0);
      price_q <= price_d;
    end
  end

  // FIFO storage; contents are only observed through the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= price_in;
    end
  end

`ifdef HPC_PATH_TAG_EN
  logic [15:0] tag_mem_q [FIFO_DEPTH];
  logic [15:0] tag_q, tag_d;

  // Next head tag, mirroring the price head selection.
  always_comb begin
    tag_d = '0;
    if (count_d != '0) begin
      tag_d = bypass ? path_q : tag_mem_q[rptr_d];
    end
  end

  // Tag storage written alongside the price word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem_q[wptr_q] <= path_q;
    end
  end

  // Registered head tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign out_tag = tag_q;
`else
  assign out_tag = '0;
`endif

  assign core_rst  = core_rst_q;
  assign core_en   = core_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign out_valid = valid_q;
  assign out_price = price_q;

endmodule

// File: tb/tb_heston_path_sequencer.sv
// Scoreboard bench for heston_path_sequencer (N_CORES=2, STEPS=4, WARMUP=2, FIFO_DEPTH=4).
// Stimulus pushes each expected capture into a queue in the cycle it should be sampled; a monitor
// pops and compares whenever the DUT hands an entry downstream.
module tb_heston_path_sequencer;

  localparam int DW     = 64;
  localparam int STEPS  = 4;
  localparam int WARMUP = 2;
  localparam int DEPTH  = 4;
  // Cycle (relative to the start cycle) in which the first capture samples price_in.
  localparam int CAP0   = 3 + WARMUP + STEPS;

  localparam logic [DW-1:0] BASE  = {32'h3F80_0000, 32'h42C8_0000};
  localparam logic [DW-1:0] NOISE = {32'hDEAD_0000, 32'hBEEF_0000};

  typedef struct packed {
    logic [DW-1:0] price;
    logic [15:0]   tag;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst, start, abort, out_ready;
  logic [15:0]   num_paths;
  logic [DW-1:0] price_in;
  logic          core_rst, core_en, out_valid, busy, done, overflow;
  logic [DW-1:0] out_price;
  logic [15:0]   out_tag;

  entry_t exp_q[$];
  entry_t mon_e;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     rel, paths, occ, fin;
  bit     running, vary, exp_ovf;

  heston_path_sequencer #(
    .N_CORES   (2),
    .PW        (32),
    .STEPS     (STEPS),
    .WARMUP    (WARMUP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .num_paths(num_paths),
    .price_in (price_in),
    .core_rst (core_rst),
    .core_en  (core_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_price(out_price),
    .out_tag  (out_tag),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (rel %0d): got %0h required %0h", name, rel, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] cap_price(input int p);
    logic [31:0] hi, lo;
    hi = 32'h3F80_0000 + 32'(p);
    lo = 32'h42C8_0000 + 32'(p);
    return {hi, lo};
  endfunction

  // One clock cycle: drive price_in, predict capture/drop, then advance past the edge.
  task automatic cyc();
    int     p;
    bit     cap, pop;
    entry_t e;
    cap = 1'b0;
    p   = 0;
    if (running && !abort && !rst && rel >= CAP0 && ((rel - CAP0) % STEPS) == 0 &&
        ((rel - CAP0) / STEPS) < paths) begin
      cap = 1'b1;
      p   = (rel - CAP0) / STEPS;
    end
    if (vary) price_in = cap ? cap_price(p) : NOISE;
    else      price_in = BASE;
    pop = (occ > 0) && out_ready;
    if (cap) begin
      if (occ == DEPTH && !pop) begin
        exp_ovf = 1'b1;
      end else begin
        e.price = price_in;
`ifdef HPC_PATH_TAG_EN
        e.tag = 16'(p);
`else
        e.tag = 16'd0;
`endif
        exp_q.push_back(e);
        occ++;
      end
    end
    if (pop) occ--;
    @(posedge clk);
    #1;
    rel++;
    if (abort || rst) begin
      exp_q.delete();
      occ     = 0;
      running = 1'b0;
    end
    if (rst) exp_ovf = 1'b0;
  endtask

  task automatic start_run(input int n);
    num_paths = 16'(n);
    start     = 1'b1;
    paths     = n;
    rel       = 0;
    running   = 1'b1;
    exp_ovf   = 1'b0;
    fin       = (n == 0) ? 1 : CAP0 + STEPS * (n - 1) + 1;
    cyc();
    start = 1'b0;
  endtask

  // Control outputs expected at the current relative cycle of a run ending in FIN at 'fin'.
  task automatic check_ctl();
    logic exp_en, exp_rst;
    exp_en = (fin > 1) && (rel >= 1) && (rel <= 3);
    check("core_en", core_en, exp_en);
    if (rel != fin) begin
      exp_rst = (rel <= 2) || (rel > fin);
      check("core_rst", core_rst, exp_rst);
    end
    check("busy", busy, (rel >= 1) && (rel <= fin));
    check("done", done, rel == fin);
  endtask

  task automatic check_reset(input string name);
    check({name, "_core_rst"}, core_rst, 1'b1);
    check({name, "_core_en"}, core_en, 1'b0);
    check({name, "_out_valid"}, out_valid, 1'b0);
    check({name, "_out_price"}, out_price, '0);
    check({name, "_out_tag"}, out_tag, '0);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_done"}, done, 1'b0);
    check({name, "_overflow"}, overflow, 1'b0);
  endtask

  task automatic drain(input string name);
    int budget;
    budget    = 4 * DEPTH + 4;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      cyc();
      budget--;
    end
    check({name, "_entries_left"}, exp_q.size(), 0);
    check({name, "_valid_after"}, out_valid, 1'b0);
  endtask

  // Monitor: compare each entry as it is accepted downstream.
  always @(negedge clk) begin
    if (!rst && !abort && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_entry: got price %0h tag %0h, required no entry", out_price,
                 out_tag);
      end else if (out_ready) begin
        mon_e = exp_q.pop_front();
        check("entry_price", out_price, mon_e.price);
        check("entry_tag", out_tag, mon_e.tag);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; num_paths = '0;
    price_in = BASE; running = 1'b0; vary = 1'b0; exp_ovf = 1'b0; occ = 0; rel = 0;
    paths = 0; fin = 0;
    cyc();
    cyc();
    check_reset("init");
    rst = 1'b0;
    cyc();

    // Basic run: three paths, constant prices, downstream always ready.
    out_ready = 1'b1;
    vary      = 1'b0;
    start_run(3);
    while (rel <= fin + 1) begin
      check_ctl();
      cyc();
    end
    drain("basic");
    check("basic_overflow", overflow, 1'b0);

    // Overflow: six paths into a four-deep FIFO with no pops.
    out_ready = 1'b0;
    vary      = 1'b1;
    start_run(6);
    while (rel <= fin + 1) begin
      check("ovf_overflow", overflow, exp_ovf);
      cyc();
    end
    check("ovf_valid_held", out_valid, 1'b1);
    drain("ovf");
    check("ovf_sticky", overflow, 1'b1);

    // Full FIFO with a pop in exactly the capture cycle of the fifth path.
    out_ready = 1'b0;
    start_run(5);
    check("full_ovf_cleared", overflow, 1'b0);
    while (rel <= fin + 1) begin
      out_ready = (rel == CAP0 + 4 * STEPS);
      check("full_overflow", overflow, exp_ovf);
      cyc();
    end
    out_ready = 1'b0;
    check("full_no_ovf", overflow, 1'b0);
    drain("full");

    // Abort at step 2 of path 1 with path 0 still queued.
    out_ready = 1'b0;
    start_run(3);
    while (rel < CAP0 + 3) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_core_rst", core_rst, 1'b1);
    check("abort_core_en", core_en, 1'b0);
    check("abort_valid", out_valid, 1'b0);
    repeat (6) begin
      check("abort_done", done, 1'b0);
      cyc();
    end

    // Abort in the final capture cycle discards the capture and suppresses done.
    out_ready = 1'b1;
    start_run(1);
    while (rel < CAP0) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    repeat (3) begin
      check("abort_cap_done", done, 1'b0);
      check("abort_cap_valid", out_valid, 1'b0);
      cyc();
    end

    // Abort and start together in IDLE: start is ignored.
    num_paths = 16'd2;
    start     = 1'b1;
    abort     = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", busy, 1'b0);
    check("abort_start_core_en", core_en, 1'b0);

    // Clean restart after abort.
    start_run(2);
    while (rel <= fin + 1) begin
      check_ctl();
      cyc();
    end
    drain("restart");

    // Zero paths: straight to FIN, cores never enabled, nothing captured.
    start_run(0);
    repeat (4) begin
      check_ctl();
      check("zero_valid", out_valid, 1'b0);
      cyc();
    end

    // Reset during WARM with two entries left in the FIFO; start held during reset.
    out_ready = 1'b0;
    start_run(2);
    while (rel <= fin + 1) cyc();
    start_run(1);
    while (rel < 4) cyc();
    check("warm_core_en", core_en, 1'b0);
    check("warm_valid", out_valid, 1'b1);
    rst       = 1'b1;
    start     = 1'b1;
    num_paths = 16'd5;
    cyc();
    check_reset("rst1");
    cyc();
    check_reset("rst2");
    rst   = 1'b0;
    start = 1'b0;
    cyc();
    check_reset("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
